// File: rtl/mac_seq_pkg.sv
// rtl/mac_seq_pkg.sv - shared types and widths for the mac segment sequencer
package mac_seq_pkg;

  localparam int P_BC    = 8;
  localparam int P_BT    = 8;
  localparam int P_DEPTH = 4;
  localparam int P_LAT   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [P_BC-1:0] c0;
    logic [P_BC-1:0] c1;
    logic [P_BT-1:0] n;
  } desc_t;

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mac_seq_fifo.sv
// rtl/mac_seq_fifo.sv - first-word-fall-through descriptor FIFO
module mac_seq_fifo
  import mac_seq_pkg::*;
#(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [W-1:0]                din,
  output logic [W-1:0]                dout,
  output logic                        empty,
  output logic                        full,
  output logic [level_w(DEPTH)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          w_do_push;
  logic          w_do_pop;

  // full comes from the registered level, so a same-edge pop never frees a slot early
  assign empty     = (r_level == '0);
  assign full      = (r_level == LW'(DEPTH));
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign dout      = r_mem[r_rptr];
  assign level     = r_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      r_level <= r_level + LW'(w_do_push) - LW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !rst) r_mem[r_wptr] <= din;
  end

endmodule

// File: rtl/mac_seq.sv
// rtl/mac_seq.sv - sweeps t over each queued segment and drives the mac inputs
module mac_seq
  import mac_seq_pkg::*;
#(
  parameter int BC    = P_BC,
  parameter int BT    = P_BT,
  parameter int DEPTH = P_DEPTH,
  parameter int LAT   = P_LAT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [BC-1:0]               s_c0,
  input  logic [BC-1:0]               s_c1,
  input  logic [BT-1:0]               s_n,
  output logic [BC-1:0]               mac_c0,
  output logic [BC-1:0]               mac_c1,
  output logic [BT-1:0]               mac_t,
  output logic                        mac_valid,
  output logic                        m_valid,
  output logic                        m_last,
  output logic                        busy,
  output logic                        done,
  output logic [level_w(DEPTH)-1:0]   level
);

  localparam int DW = 2 * BC + BT;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [BC-1:0] r_c0;
  logic [BC-1:0] r_c1;
  logic [BT-1:0] r_t;
  logic [BT-1:0] r_cnt;
  logic          r_done;
  logic [LAT-1:0] r_vld_dly;
  logic [LAT-1:0] r_last_dly;

  logic [DW-1:0] w_din;
  logic [DW-1:0] w_dout;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_load;
  logic          w_done_nxt;
  logic          w_last_int;
  logic [BC-1:0] w_head_c0;
  logic [BC-1:0] w_head_c1;
  logic [BT-1:0] w_head_n;

  assign w_din     = {s_c0, s_c1, s_n};
  assign w_head_c0 = w_dout[DW-1 -: BC];
  assign w_head_c1 = w_dout[BT+BC-1 -: BC];
  assign w_head_n  = w_dout[BT-1:0];

  mac_seq_fifo #(.W(DW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .empty (w_empty),
    .full  (w_full),
    .level (level)
  );

  assign s_ready = !w_full && !rst;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head_n != '0) begin
            w_load      = 1'b1;
            w_state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (w_last_int) begin
          if (!w_empty) begin
            w_pop = 1'b1;
            if (w_head_n != '0) w_load = 1'b1;
            else                w_state_nxt = IDLE;
          end else begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mac_valid  = (r_state == RUN);
    busy       = (r_state == RUN);
    w_last_int = (r_state == RUN) && (r_t == r_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_c0   <= '0;
      r_c1   <= '0;
      r_t    <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_load) begin
        r_c0  <= w_head_c0;
        r_c1  <= w_head_c1;
        r_t   <= '0;
        r_cnt <= w_head_n - BT'(1);
      end else if (r_state == RUN && !w_last_int) begin
        r_t <= r_t + BT'(1);
      end
    end
  end

  // Strobes are delayed to line up with the mac y output
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_dly  <= '0;
      r_last_dly <= '0;
    end else begin
      r_vld_dly[0]  <= mac_valid;
      r_last_dly[0] <= w_last_int;
      for (int i = 1; i < LAT; i++) begin
        r_vld_dly[i]  <= r_vld_dly[i-1];
        r_last_dly[i] <= r_last_dly[i-1];
      end
    end
  end

  assign mac_c0  = r_c0;
  assign mac_c1  = r_c1;
  assign mac_t   = r_t;
  assign done    = r_done;
  assign m_valid = r_vld_dly[LAT-1];
  assign m_last  = r_last_dly[LAT-1];

endmodule

// File: tb/tb_mac_seq.sv
// tb/tb_mac_seq.sv - directed vector bench for mac_seq
module tb_mac_seq;
  import mac_seq_pkg::*;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_c0 = '0;
  logic [7:0] s_c1 = '0;
  logic [7:0] s_n = '0;
  logic [7:0] mac_c0;
  logic [7:0] mac_c1;
  logic [7:0] mac_t;
  logic       mac_valid;
  logic       m_valid;
  logic       m_last;
  logic       busy;
  logic       done;
  logic [2:0] level;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  mac_seq #(.BC(8), .BT(8), .DEPTH(4), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_c0      (s_c0),
    .s_c1      (s_c1),
    .s_n       (s_n),
    .mac_c0    (mac_c0),
    .mac_c1    (mac_c1),
    .mac_t     (mac_t),
    .mac_valid (mac_valid),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done),
    .level     (level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       sv;
    desc_t      d;
    logic       mv;
    logic [7:0] mt;
    logic [7:0] mc0;
    logic [7:0] mc1;
    logic       ov;
    logic       ol;
    logic       b;
    logic       dn;
    logic [2:0] lvl;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(input logic sv, input int c0, input int c1, input int n,
                              input logic mv, input int mt, input int mc0, input int mc1,
                              input logic ov, input logic ol, input logic b, input logic dn,
                              input int lvl);
    vec_t v;
    v.sv = sv; v.d.c0 = c0[7:0]; v.d.c1 = c1[7:0]; v.d.n = n[7:0];
    v.mv = mv; v.mt = mt[7:0]; v.mc0 = mc0[7:0]; v.mc1 = mc1[7:0];
    v.ov = ov; v.ol = ol; v.b = b; v.dn = dn; v.lvl = lvl[2:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic sv, input int c0, input int c1, input int n);
    s_valid = sv;
    s_c0 = c0[7:0];
    s_c1 = c1[7:0];
    s_n = n[7:0];
  endtask

  initial begin
    int bad;
    int w;
    int samples;
    int exp_t;
    int t254_cyc;
    int mlast_cyc;
    int mlast_cnt;
    int done_cnt;
    int mv_cnt;

    //         sv c0 c1 n   mv mt mc0 mc1 ov ol b  d  lvl
    vecs[0]  = mk(1, 12, 6, 4, 0, 0, 0,  0,  0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0,  0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 1);
    vecs[2]  = mk(0, 0,  0, 0, 1, 0, 12, 6,  0, 0, 1, 0, 0);
    vecs[3]  = mk(0, 0,  0, 0, 1, 1, 12, 6,  0, 0, 1, 0, 0);
    vecs[4]  = mk(0, 0,  0, 0, 1, 2, 12, 6,  1, 0, 1, 0, 0);
    vecs[5]  = mk(0, 0,  0, 0, 1, 3, 12, 6,  1, 0, 1, 0, 0);
    vecs[6]  = mk(0, 0,  0, 0, 0, 3, 12, 6,  1, 0, 0, 1, 0);
    vecs[7]  = mk(0, 0,  0, 0, 0, 3, 12, 6,  1, 1, 0, 0, 0);
    vecs[8]  = mk(0, 0,  0, 0, 0, 3, 12, 6,  0, 0, 0, 0, 0);
    vecs[9]  = mk(1, 12, 6, 3, 0, 3, 12, 6,  0, 0, 0, 0, 0);
    vecs[10] = mk(1, 5,  2, 2, 0, 3, 12, 6,  0, 0, 0, 0, 1);
    vecs[11] = mk(0, 0,  0, 0, 1, 0, 12, 6,  0, 0, 1, 0, 1);
    vecs[12] = mk(0, 0,  0, 0, 1, 1, 12, 6,  0, 0, 1, 0, 1);
    vecs[13] = mk(0, 0,  0, 0, 1, 2, 12, 6,  1, 0, 1, 0, 1);
    vecs[14] = mk(0, 0,  0, 0, 1, 0, 5,  2,  1, 0, 1, 0, 0);
    vecs[15] = mk(0, 0,  0, 0, 1, 1, 5,  2,  1, 1, 1, 0, 0);
    vecs[16] = mk(0, 0,  0, 0, 0, 1, 5,  2,  1, 0, 0, 1, 0);
    vecs[17] = mk(0, 0,  0, 0, 0, 1, 5,  2,  1, 1, 0, 0, 0);
    vecs[18] = mk(0, 0,  0, 0, 0, 1, 5,  2,  0, 0, 0, 0, 0);
    vecs[19] = mk(1, 1,  1, 0, 0, 1, 5,  2,  0, 0, 0, 0, 0);
    vecs[20] = mk(1, 7,  3, 2, 0, 1, 5,  2,  0, 0, 0, 0, 1);
    vecs[21] = mk(0, 0,  0, 0, 0, 1, 5,  2,  0, 0, 0, 0, 1);
    vecs[22] = mk(0, 0,  0, 0, 1, 0, 7,  3,  0, 0, 1, 0, 0);
    vecs[23] = mk(0, 0,  0, 0, 1, 1, 7,  3,  0, 0, 1, 0, 0);
    vecs[24] = mk(0, 0,  0, 0, 0, 1, 7,  3,  1, 0, 0, 1, 0);
    vecs[25] = mk(0, 0,  0, 0, 0, 1, 7,  3,  1, 1, 0, 0, 0);
    vecs[26] = mk(0, 0,  0, 0, 0, 1, 7,  3,  0, 0, 0, 0, 0);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", s_ready, 0);
    chk("rst_level", level, 0);
    chk("rst_mac_valid", mac_valid, 0);
    chk("rst_mac_t", mac_t, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;

    // single segment, back-to-back, n=0 drop
    for (int i = 0; i < 27; i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i].sv, vecs[i].d.c0, vecs[i].d.c1, vecs[i].d.n);
      #1;
      chk($sformatf("v%0d_mac_valid", i), mac_valid, vecs[i].mv);
      chk($sformatf("v%0d_mac_t", i), mac_t, vecs[i].mt);
      chk($sformatf("v%0d_mac_c0", i), mac_c0, vecs[i].mc0);
      chk($sformatf("v%0d_mac_c1", i), mac_c1, vecs[i].mc1);
      chk($sformatf("v%0d_m_valid", i), m_valid, vecs[i].ov);
      chk($sformatf("v%0d_m_last", i), m_last, vecs[i].ol);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].b);
      chk($sformatf("v%0d_done", i), done, vecs[i].dn);
      chk($sformatf("v%0d_level", i), level, vecs[i].lvl);
      chk($sformatf("v%0d_s_ready", i), s_ready, 1);
    end

    // FIFO full: long segment running, four more queued, fifth held
    @(negedge clk);
    drive(1, 0, 0, 255);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      drive(1, i, i, 2);
    end
    @(negedge clk);
    #1;
    chk("full_level", level, 4);
    chk("full_ready", s_ready, 0);
    drive(1, 5, 5, 2);
    bad = 0;
    w = 0;
    while (mac_t != 8'd254 && w < 300) begin
      @(negedge clk);
      #1;
      if (level != 3'd4 || s_ready !== 1'b0) bad++;
      w++;
    end
    chk("full_wait_t254", mac_t, 254);
    chk("full_held", bad, 0);
    @(negedge clk);
    #1;
    chk("full_after_pop_level", level, 3);
    chk("full_after_pop_ready", s_ready, 1);
    chk("full_after_pop_t", mac_t, 0);
    chk("full_after_pop_c0", mac_c0, 1);
    @(negedge clk);
    drive(0, 0, 0, 0);
    #1;
    chk("full_accept_level", level, 4);
    w = 0;
    while (!done && w < 100) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("full_drain_done", done, 1);
    chk("full_drain_level", level, 0);
    chk("full_drain_last_c0", mac_c0, 5);

    // reset mid-run with two descriptors queued
    @(negedge clk);
    drive(1, 9, 9, 200);
    @(negedge clk);
    drive(1, 1, 1, 3);
    @(negedge clk);
    drive(1, 2, 2, 3);
    @(negedge clk);
    drive(0, 0, 0, 0);
    w = 0;
    while (mac_t != 8'd50 && w < 100) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("rr_reach_t50", mac_t, 50);
    chk("rr_queued", level, 2);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rr_mac_valid", mac_valid, 0);
    chk("rr_level", level, 0);
    chk("rr_busy", busy, 0);
    chk("rr_mac_t", mac_t, 0);
    chk("rr_ready", s_ready, 0);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < LAT + 4; k++) begin
      #1;
      if (m_valid !== 1'b0 || done !== 1'b0 || mac_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("rr_quiet_after", bad, 0);

    // maximum length segment
    drive(1, 255, 255, 255);
    @(negedge clk);
    drive(0, 0, 0, 0);
    w = 0;
    while (!mac_valid && w < 10) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("max_start", mac_valid, 1);
    bad = 0; samples = 0; exp_t = 0; t254_cyc = -1; mlast_cyc = -1;
    mlast_cnt = 0; done_cnt = 0; mv_cnt = 0;
    while (mac_valid && samples < 300) begin
      #1;
      if (mac_t != exp_t[7:0] || mac_c0 != 8'd255 || mac_c1 != 8'd255) bad++;
      if (mac_t == 8'd254) t254_cyc = cyc;
      if (m_last) begin mlast_cnt++; mlast_cyc = cyc; end
      if (m_valid) mv_cnt++;
      if (done) done_cnt++;
      samples++;
      exp_t++;
      @(negedge clk);
    end
    for (int k = 0; k < LAT + 3; k++) begin
      #1;
      if (m_last) begin mlast_cnt++; mlast_cyc = cyc; end
      if (m_valid) mv_cnt++;
      if (done) done_cnt++;
      @(negedge clk);
    end
    chk("max_samples", samples, 255);
    chk("max_sweep", bad, 0);
    chk("max_m_valid_cnt", mv_cnt, 255);
    chk("max_m_last_cnt", mlast_cnt, 1);
    chk("max_m_last_align", mlast_cyc - t254_cyc, LAT);
    chk("max_done_cnt", done_cnt, 1);
    chk("max_final_t", mac_t, 254);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
